// File: rtl/ss_pkg.sv
// ss_pkg: shared seven-segment definitions (active-high abcdefg encoding, bit 6 = a).
package ss_pkg;
    typedef logic [3:0] nibble_t;
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
endpackage

// File: rtl/ss_hex_decoder.sv
// ss_hex_decoder: combinational hex nibble to active-high segment pattern.
module ss_hex_decoder
    import ss_pkg::*;
(
    input  nibble_t    i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_TABLE[i_nib];
endmodule

// File: rtl/ss_mux_driver.sv
// ss_mux_driver: scanning multi-digit seven-segment driver with guard interval,
// leading-zero blanking and frame-synchronous shadow-to-active value update.
module ss_mux_driver
    import ss_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic                r_run;
    logic [4*DIGITS-1:0] r_shd_val, r_act_val;
    logic [DIGITS-1:0]   r_shd_dp, r_act_dp;
    logic                r_shd_blk, r_act_blk;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_fd;

    logic                w_slot_end, w_frame_end, w_start, w_dp, w_blank;
    nibble_t             w_nib;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_an;

    assign w_slot_end  = r_cnt == CW'(CLK_DIV - 1);
    assign w_frame_end = r_run && w_slot_end && r_idx == IW'(DIGITS - 1);
    // The first enabled edge after idle behaves as a frame boundary.
    assign w_start     = enable && !r_run;
    assign w_nib       = nibble_t'(r_act_val >> {r_idx, 2'b00});
    assign w_dp        = 1'(r_act_dp >> r_idx);
    assign w_an        = DIGITS'(1) << r_idx;
    // Digit is a leading zero when it and every more significant nibble are zero.
    assign w_blank     = r_act_blk && r_idx != '0 && (r_act_val >> {r_idx, 2'b00}) == '0;

    ss_hex_decoder u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_run     <= 1'b0;
            r_shd_val <= '0;
            r_shd_dp  <= '0;
            r_shd_blk <= 1'b0;
            r_act_val <= '0;
            r_act_dp  <= '0;
            r_act_blk <= 1'b0;
        end else begin
            if (load) begin
                r_shd_val <= value;
                r_shd_dp  <= dp_in;
                r_shd_blk <= blank_en;
            end
            if (w_start || (enable && w_frame_end)) begin
                r_act_val <= r_shd_val;
                r_act_dp  <= r_shd_dp;
                r_act_blk <= r_shd_blk;
            end
            if (!enable || w_start) begin
                r_cnt <= '0;
                r_idx <= '0;
            end else if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_run <= enable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= {7{SEG_ACTIVE_LOW}};
            r_dp  <= SEG_ACTIVE_LOW;
            r_an  <= {DIGITS{AN_ACTIVE_LOW}};
            r_fd  <= 1'b0;
        end else begin
            r_seg <= (w_blank ? 7'h00 : w_seg) ^ {7{SEG_ACTIVE_LOW}};
            r_dp  <= (w_dp && !w_blank) ^ SEG_ACTIVE_LOW;
            r_an  <= ((enable && r_run && r_cnt >= CW'(GUARD)) ? w_an : '0) ^ {DIGITS{AN_ACTIVE_LOW}};
            r_fd  <= enable && w_frame_end;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_fd;
endmodule

// File: tb/tb_ss_mux_driver.sv
// tb_ss_mux_driver: directed bench for a 4-digit, CLK_DIV=4, GUARD=1, active-low build.
module tb_ss_mux_driver;
    logic        clk = 1'b0;
    logic        rst_n, enable, load, blank_en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    int          n_cmp = 0;
    int          n_err = 0;

    // Expected pin values per frame of the main scan run, indexed [frame][digit].
    logic [6:0] exp_seg [5][4] = '{
        '{7'h01, 7'h08, 7'h12, 7'h4F},
        '{7'h01, 7'h08, 7'h12, 7'h4F},
        '{7'h01, 7'h24, 7'h7F, 7'h7F},
        '{7'h01, 7'h24, 7'h7F, 7'h7F},
        '{7'h00, 7'h00, 7'h00, 7'h00}
    };
    logic [3:0] exp_dp [5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'b1011};
    logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    ss_mux_driver #(
        .DIGITS(4), .CLK_DIV(4), .GUARD(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_en   (blank_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_en = 1'b0;
        value = 16'h0; dp_in = 4'h0;
        #12;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; load = 1'b1; value = 16'h12A0;
        @(negedge clk);
        load = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("start_an", 32'(an), 32'hF);
        chk("start_fd", 32'(frame_done), 32'h0);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            chk($sformatf("an_k%0d", k), 32'(an), (k % 4 == 0) ? 32'hF : 32'(exp_an[(k / 4) % 4]));
            chk($sformatf("seg_k%0d", k), 32'(seg), 32'(exp_seg[k / 16][(k / 4) % 4]));
            chk($sformatf("dp_k%0d", k), 32'(dp), 32'(exp_dp[k / 16][(k / 4) % 4]));
            chk($sformatf("fd_k%0d", k), 32'(frame_done), (k % 16 == 15) ? 32'h1 : 32'h0);
            if (k == 16) begin
                load = 1'b1; value = 16'h0050; blank_en = 1'b1; dp_in = 4'b1000;
            end else if (k == 46) begin
                load = 1'b1; value = 16'h8888; blank_en = 1'b0; dp_in = 4'b0100;
            end else begin
                load = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        chk("mid_an_active", 32'(an), 32'hD);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_an", 32'(an), 32'hF);
        chk("dis_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        chk("dis_an_hold", 32'(an), 32'hF);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_an", 32'(an), 32'hF);
        chk("reen_fd", 32'(frame_done), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("reen_an_k%0d", k), 32'(an), (k == 0) ? 32'hF : 32'hE);
            chk($sformatf("reen_seg_k%0d", k), 32'(seg), 32'h00);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'h1);
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_fd", 32'(frame_done), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ss_mux_driver.md
# ss_mux_driver

Time-multiplexed driver for a DIGITS-wide common-anode or common-cathode seven-segment display. It is the scanning successor to the single-digit combinational segment decoder:
- full hex (0–F) decoding;
- per-digit decimal points;
- leading-zero blanking;
- a refresh counter that walks the anodes, with an anti-ghosting guard interval;
- tear-free frame-synchronous update of the displayed value.

It sits between any numeric datapath and the board's segment and anode pins.

## Interface
- DIGITS, default 4: number of digits, legal range 1..8.
- CLK_DIV, default 50000: clock cycles per digit slot, ≥ 2.
- GUARD, default 2: cycles at the start of each slot during which all anodes are off, < CLK_DIV.
- SEG_ACTIVE_LOW, default 1: polarity of seg and dp; 1 means a lit segment is driven 0.
- AN_ACTIVE_LOW, default 1: polarity of an; 1 means the selected digit is driven 0.

- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enable.
- load  in  1  capture value, dp_in and blank_en into the shadow register.
- value  in  4*DIGITS  hex nibbles; nibble 0 (bits [3:0]) is the rightmost digit.
- dp_in  in  DIGITS  decimal point per digit; bit i belongs to digit i.
- blank_en  in  1  leading-zero suppression.
- seg  out  7  segments {a,b,c,d,e,f,g} on seg[6:0].
- dp  out  1  decimal point.
- an  out  DIGITS  anode / digit select, one-hot when active.
- frame_done  out  1  one-cycle pulse when the slot of the last digit ends.

## Operation
**Reset**
- Clears the counter, digit index, shadow register and active register.
- seg, dp and an go all inactive at their configured polarity; frame_done = 0.

**Load**
- load = 1 captures the inputs into the shadow register at that edge.
- The shadow register is copied into the active register only at a frame boundary: the edge at which the index wraps from DIGITS-1 to 0.
- If load coincides with a boundary, the copy takes the old shadow contents. The new value appears one frame later.

**Scan**
- cnt runs 0..CLK_DIV-1.
- At cnt = CLK_DIV-1, cnt returns to 0 and idx advances modulo DIGITS.
- The wrap from DIGITS-1 to 0 pulses frame_done and performs the shadow-to-active copy.

**Guard**
- While cnt < GUARD, an is all inactive; seg and dp already carry the new digit.

**Blanking**
- With blank_en active, digit i is blanked (seg and dp off) when nibbles DIGITS-1..i are all zero and i ≠ 0.
- Digit 0 is never blanked.
- A lit dp_in does not keep a blanked digit lit.

**Decoding (active-high, bit order abcdefg)**
- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111
- SEG_ACTIVE_LOW inverts seg and dp.

**Enable**
- enable = 0 synchronously clears cnt and idx, holds an inactive and frame_done at 0. load still works.
- The first edge with enable = 1 is treated as a frame boundary: the copy happens and digit 0 slot starts at cnt = 0. frame_done does not pulse on this edge.

## Timing
- seg, dp, an and frame_done are registered, with one cycle of latency from cnt/idx state to the pins.
- A slot lasts CLK_DIV cycles. A frame lasts DIGITS*CLK_DIV cycles.
- an is active for CLK_DIV-GUARD cycles per slot.
- frame_done is high exactly one cycle per frame.
- DIGITS = 1: idx stays at 0. Every slot end is a frame boundary.
- Asserting rst_n low mid-frame forces all outputs inactive immediately, without waiting for clk.

## Structure
- Package ss_pkg holds:
  - the 16-entry segment constant table (active-high, abcdefg);
  - the segment index constants SEG_A..SEG_G;
  - the nibble typedef.
- Sub-module ss_hex_decoder: combinational 4-bit to 7-bit lookup using ss_pkg, instantiated once on the muxed nibble.
- Top level holds: counter, index, shadow/active registers, blanking logic, polarity inversion, output registers.

## Test plan
Bench parameters: DIGITS = 4, CLK_DIV = 4, GUARD = 1, both polarities active-low.

- **Reset:** hold rst_n low → seg = 7'h7F, dp = 1, an = 4'hF, frame_done = 0.
- **Scan:** release reset, enable = 1, load value 16'h12A0 → next frame:
  - an cycles 1110, 1101, 1011, 0111, each active 3 of 4 cycles;
  - seg = 7'h01, 7'h08, 7'h12, 7'h4F;
  - frame_done pulses once every 16 cycles.
- **Blanking:** blank_en = 1, value 16'h0050 → digits 3 and 2 have seg = 7'h7F; digit 1 shows 7'h24; digit 0 shows 7'h01.
- **Frame boundary:** load 16'h8888 on the same edge as frame_done → the following frame still shows the old value; the frame after shows seg = 7'h00 on all digits.
- **Decimal point:** dp_in = 4'b0100 → dp = 0 only during the digit 2 slot.
- **Enable and async reset:** drop enable mid-frame → an = 4'hF next cycle; re-enable → the digit 0 slot restarts. Assert rst_n low between clock edges → outputs go inactive at once.
